param_ram: RTL and testbench

- Parametrised single-port synchronous RAM; next generation of the team's 16x8 RAM.
- Generalised data and address width, per-byte write enables, and optional output register.
- Adds a hardware clear sweep after reset and on request, a busy/reject handshake, and a read-valid strobe.
- Serves as the scratch/buffer memory for datapath blocks that need known-initialised storage.

---
 rtl/param_ram.sv | 141 ++++++++++++++
 tb/tb_param_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_ram.sv
// param_ram: parametrised single-port synchronous RAM.
// Byte-lane write enables, read-first on same-address read/write, optional
// output register, and a hardware clear sweep that fills every word with
// INIT_VAL after reset and on request. Accesses arriving while the sweep
// runs (or colliding with a clear request) are dropped and flagged.
// DATA_W must be a multiple of 8.
module param_ram #(
    parameter int                  DATA_W   = 8,
    parameter int                  ADDR_W   = 4,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0,
    parameter int                  OUT_REG  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      din,
    input  logic [DATA_W/8-1:0]    be,
    output logic [DATA_W-1:0]      dout,
    output logic                   rvalid,
    output logic                   busy,
    output logic                   rejected
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_cnt;
    logic                 r_rejected;
    logic [DATA_W-1:0]    r_dout;
    logic                 r_rvalid;

    logic                 w_idle;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_drop;
    logic [DATA_W-1:0]    w_rd_word;

    // A clear request in IDLE takes priority over any access in the same cycle.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_wr_ok = w_idle && we && !clr;
    assign w_rd_ok = w_idle && re && !clr;
    assign w_drop  = w_idle ? (clr && (we || re)) : (we || re || clr);

    // Sweep FSM: walk the counter through every word, then accept traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_rejected <= 1'b0;
        end else begin
            r_rejected <= w_drop;
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // One narrow array per byte lane so each lane's enable maps onto its own RAM.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        // Sweep writes INIT_VAL; otherwise accepted writes update enabled lanes.
        always_ff @(posedge clk) begin
            if (!w_idle) begin
                r_mem[r_cnt] <= INIT_VAL[8*gi +: 8];
            end else if (w_wr_ok && be[gi]) begin
                r_mem[addr] <= din[8*gi +: 8];
            end
        end

        // Raw lane data; captured by the output stage, which gives read-first.
        assign w_rd_word[8*gi +: 8] = r_mem[addr];
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_pipe_data;
        logic              r_pipe_vld;

        // Two-stage read: array capture, then output register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipe_data <= '0;
                r_pipe_vld  <= 1'b0;
                r_dout      <= '0;
                r_rvalid    <= 1'b0;
            end else begin
                r_pipe_vld <= w_rd_ok;
                if (w_rd_ok) begin
                    r_pipe_data <= w_rd_word;
                end
                r_rvalid <= r_pipe_vld;
                if (r_pipe_vld) begin
                    r_dout <= r_pipe_data;
                end
            end
        end
    end else begin : g_no_out_reg
        // Single-stage read: dout updates only on an accepted read.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dout   <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_dout <= w_rd_word;
                end
            end
        end
    end

    assign dout     = r_dout;
    assign rvalid   = r_rvalid;
    assign busy     = (r_state == ST_CLEAR);
    assign rejected = r_rejected;

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed test of param_ram, 16x16, with two instances
// sharing stimulus: u_dut0 (latency 1) and u_dut1 (output register, latency 2).
module tb_param_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [1:0]  be;

    logic [15:0] dout0, dout1;
    logic        rvalid0, rvalid1;
    logic        busy0, busy1;
    logic        rejected0, rejected1;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    param_ram #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'h0000), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr),
        .din(din), .be(be), .dout(dout0), .rvalid(rvalid0), .busy(busy0),
        .rejected(rejected0)
    );

    param_ram #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'h0000), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr),
        .din(din), .be(be), .dout(dout1), .rvalid(rvalid1), .busy(busy1),
        .rejected(rejected1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clr = 1'b0; we = 1'b0; re = 1'b0; be = 2'b00; din = 16'h0000;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        set_idle();
        we = 1'b1; addr = a; din = d; be = b;
        $display("[TB] write addr=%0d din=0x%04h be=%b", a, d, b);
        tick();
        we = 1'b0;
    endtask

    task automatic count_busy(input int start, output int cnt);
        cnt = start;
        while (busy0 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b0;
        addr = 4'd0;
        set_idle();
        tick();
        tick();

        // Reset state
        check("rst_dout0", dout0, 16'h0000);
        check("rst_rvalid0", {15'b0, rvalid0}, 16'h0);
        check("rst_rejected0", {15'b0, rejected0}, 16'h0);
        check("rst_busy0", {15'b0, busy0}, 16'h1);
        check("rst_busy1", {15'b0, busy1}, 16'h1);
        check("rst_rvalid1", {15'b0, rvalid1}, 16'h0);

        // Release reset: busy for exactly 16 cycles
        rst = 1'b1;
        count_busy(0, n);
        $display("[TB] initial sweep busy cycles=%0d", n);
        check("sweep_len", 16'(n), 16'd16);
        check("sweep_busy1", {15'b0, busy1}, 16'h0);

        // Read every address: all zero, rvalid one cycle after re
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; addr = 4'(a);
            tick();
            $display("[TB] read addr=%0d dout0=0x%04h rvalid0=%0b", a, dout0, rvalid0);
            check("clr_read_dout0", dout0, 16'h0000);
            check("clr_read_rv0", {15'b0, rvalid0}, 16'h1);
        end
        re = 1'b0;
        tick();
        check("clr_read_end_rv0", {15'b0, rvalid0}, 16'h0);
        check("clr_read_end_rv1", {15'b0, rvalid1}, 16'h1);
        check("clr_read_end_dout1", dout1, 16'h0000);

        // Full-word writes, then back-to-back reads
        write(4'd1, 16'hAAAA, 2'b11);
        write(4'd2, 16'hBBBB, 2'b11);
        write(4'd3, 16'hCCCC, 2'b11);
        check("wr_no_rv1", {15'b0, rvalid1}, 16'h0);
        re = 1'b1; addr = 4'd1; tick();
        $display("[TB] read addr=1 dout0=0x%04h", dout0);
        check("b2b_1_dout0", dout0, 16'hAAAA);
        check("b2b_1_rv0", {15'b0, rvalid0}, 16'h1);
        check("b2b_1_rv1", {15'b0, rvalid1}, 16'h0);
        addr = 4'd2; tick();
        $display("[TB] read addr=2 dout0=0x%04h dout1=0x%04h", dout0, dout1);
        check("b2b_2_dout0", dout0, 16'hBBBB);
        check("b2b_2_rv0", {15'b0, rvalid0}, 16'h1);
        check("b2b_2_dout1", dout1, 16'hAAAA);
        check("b2b_2_rv1", {15'b0, rvalid1}, 16'h1);
        addr = 4'd3; tick();
        $display("[TB] read addr=3 dout0=0x%04h dout1=0x%04h", dout0, dout1);
        check("b2b_3_dout0", dout0, 16'hCCCC);
        check("b2b_3_rv0", {15'b0, rvalid0}, 16'h1);
        check("b2b_3_dout1", dout1, 16'hBBBB);
        re = 1'b0; addr = 4'd0; tick();
        check("b2b_end_rv0", {15'b0, rvalid0}, 16'h0);
        check("b2b_hold_dout0", dout0, 16'hCCCC);
        check("b2b_end_dout1", dout1, 16'hCCCC);
        check("b2b_end_rv1", {15'b0, rvalid1}, 16'h1);
        tick();
        check("b2b_idle_rv1", {15'b0, rvalid1}, 16'h0);
        check("b2b_hold_dout1", dout1, 16'hCCCC);

        // Partial byte write, then empty byte-enable no-op
        write(4'd1, 16'h1234, 2'b01);
        re = 1'b1; addr = 4'd1; tick();
        $display("[TB] read addr=1 dout0=0x%04h", dout0);
        check("be01_dout0", dout0, 16'hAA34);
        re = 1'b0;
        write(4'd1, 16'hFFFF, 2'b00);
        check("be01_dout1", dout1, 16'hAA34);
        re = 1'b1; addr = 4'd1; tick();
        $display("[TB] read addr=1 dout0=0x%04h", dout0);
        check("be00_dout0", dout0, 16'hAA34);
        re = 1'b0; tick();
        check("be00_dout1", dout1, 16'hAA34);

        // Same-cycle read and write to the same address: read-first
        we = 1'b1; re = 1'b1; addr = 4'd2; din = 16'h5555; be = 2'b11;
        tick();
        $display("[TB] read+write addr=2 dout0=0x%04h", dout0);
        check("rdfirst_dout0", dout0, 16'hBBBB);
        we = 1'b0; tick();
        check("rdfirst_next_dout0", dout0, 16'h5555);
        check("rdfirst_dout1", dout1, 16'hBBBB);
        re = 1'b0; tick();
        check("rdfirst_next_dout1", dout1, 16'h5555);

        // Clear request with a colliding write, then a write during the sweep
        clr = 1'b1; we = 1'b1; addr = 4'd1; din = 16'hFFFF; be = 2'b11;
        tick();
        $display("[TB] clr+write busy0=%0b rejected0=%0b", busy0, rejected0);
        check("clr_rej0", {15'b0, rejected0}, 16'h1);
        check("clr_rej1", {15'b0, rejected1}, 16'h1);
        check("clr_busy0", {15'b0, busy0}, 16'h1);
        clr = 1'b0; we = 1'b1; addr = 4'd5; din = 16'h9999;
        tick();
        check("sweep_wr_rej0", {15'b0, rejected0}, 16'h1);
        we = 1'b0; addr = 4'd0;
        tick();
        check("sweep_rej_pulse0", {15'b0, rejected0}, 16'h0);
        count_busy(2, n);
        $display("[TB] clr sweep busy cycles=%0d", n);
        check("clr_sweep_len", 16'(n), 16'd16);
        check("clr_no_rej_after", {15'b0, rejected0}, 16'h0);
        re = 1'b1; addr = 4'd1; tick();
        check("after_clr_a1", dout0, 16'h0000);
        addr = 4'd5; tick();
        check("after_clr_a5", dout0, 16'h0000);
        addr = 4'd2; tick();
        check("after_clr_a2", dout0, 16'h0000);
        re = 1'b0; tick();

        // Async reset with a read in flight in the output-register instance
        write(4'd3, 16'h7777, 2'b11);
        re = 1'b1; addr = 4'd3; tick();
        check("pre_rst_dout0", dout0, 16'h7777);
        re = 1'b0;
        #3 rst = 1'b0;
        #1;
        $display("[TB] async reset dout0=0x%04h rvalid1=%0b", dout0, rvalid1);
        check("arst_dout0", dout0, 16'h0000);
        check("arst_rv0", {15'b0, rvalid0}, 16'h0);
        check("arst_rv1", {15'b0, rvalid1}, 16'h0);
        check("arst_dout1", dout1, 16'h0000);
        check("arst_busy0", {15'b0, busy0}, 16'h1);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_rv1", {15'b0, rvalid1}, 16'h0);
        check("post_rst_dout1", dout1, 16'h0000);
        tick(); tick(); tick();

        // Reset again mid-sweep: sweep restarts from zero
        #3 rst = 1'b0;
        tick();
        rst = 1'b1;
        count_busy(0, n);
        $display("[TB] restarted sweep busy cycles=%0d", n);
        check("restart_sweep_len", 16'(n), 16'd16);
        re = 1'b1; addr = 4'd3; tick();
        check("restart_a3", dout0, 16'h0000);
        check("restart_rv0", {15'b0, rvalid0}, 16'h1);
        re = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
